debounce_sync: RTL
==================

// Module: debounce_sync
// PURPOSE
//  Input conditioner that sits directly upstream of dflipflop.
//  Synchronises an asynchronous level input (switch or external pin) into the clk domain.
//  Debounces it with a consecutive-cycle stability counter.
//  Drives a clean level (dout, wired to dflipflop d) plus one-cycle rise/fall pulses.
//  Counts rejected glitches for debug.
// PARAMETERS
//  SYNC_STAGES      2  flops in synchroniser chain; must be >= 2
//  DEBOUNCE_CYCLES  4  consecutive cycles of a new synced value required to accept it; must be >= 2
//  GLITCH_W         8  width of saturating glitch counter
// PORTS
//  clk         in   1         single clock, all state updates on rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  din_async   in   1         raw asynchronous level input
//  enable      in   1         0: hold dout, abort any check in progress
//  dout        out  1         debounced level (feeds dflipflop d)
//  rise_pulse  out  1         1 for exactly one cycle when dout goes 0->1
//  fall_pulse  out  1         1 for exactly one cycle when dout goes 1->0
//  busy        out  1         1 while a candidate transition is being checked
//  glitch_cnt  out  GLITCH_W  count of aborted candidate transitions
// BEHAVIOUR
//  Reset
//   - rst_n low forces all state to 0 immediately, independent of clk:
//     sync chain, cnt, state=IDLE_LO, dout, pulses, busy, glitch_cnt.
//   - Reset asserted mid-check discards the check; no pulse is emitted.
//  Synchroniser
//   - sync[0] <= din_async; sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1].
//   - Runs whenever out of reset, regardless of enable.
//  FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO
//   - IDLE_LO / IDLE_HI hold dout at 0 / 1.
//   - cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
//   - IDLE_x, enable=1, s!=dout: enter CHK_x, cnt<=1.
//   - CHK_x, enable=1, s!=dout, cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - CHK_x, enable=1, s!=dout, cnt==DEBOUNCE_CYCLES-1: toggle dout, go to the opposite IDLE,
//     cnt<=0, assert rise_pulse or fall_pulse on the same edge.
//   - CHK_x, enable=1, s==dout (glitch): back to IDLE of current dout, cnt<=0, no pulse,
//     glitch_cnt<=glitch_cnt+1 saturating at all-ones.
//   - enable=0 in any state: go to IDLE of current dout, cnt<=0, no pulse,
//     glitch_cnt unchanged, dout held.
//  Outputs
//   - All outputs are registered.
//   - busy = state is CHK_HI or CHK_LO.
//   - Pulses are 0 in every cycle except the toggle cycle.
//   - rise_pulse and fall_pulse are never both 1.
//  Latency
//   - din_async stable before rising edge E0 -> dout updates on edge
//     E0+SYNC_STAGES+DEBOUNCE_CYCLES-1 (6th edge, counting E0, at defaults).
//  Boundaries
//   - A glitch on the final check cycle aborts the check; dout does not toggle.
//   - After an abort, a fresh transition restarts at cnt=1.
//   - glitch_cnt holds at 2^GLITCH_W-1 and never wraps.
// TESTING
//  T1 reset
//   - rst_n=0 asynchronously mid-cycle with din_async=1 -> all outputs 0 before the next clk edge.
//  T2 clean rise, defaults
//   - din_async 0->1 before E0, held -> dout=1 and rise_pulse=1 at the 6th edge.
//   - rise_pulse back to 0 on the next edge.
//   - busy=1 over edges 3..5, counting E0 as edge 1.
//  T3 glitch reject
//   - din_async high for 2 cycles then low -> dout stays 0, no pulse, glitch_cnt=1.
//   - Repeat 300 times with GLITCH_W=8 -> glitch_cnt saturates at 255.
//  T4 clean fall
//   - From dout=1, din_async 1->0 held -> fall_pulse=1 for one cycle at the 6th edge, dout=0.
//  T5 enable abort
//   - Drop enable while busy=1 -> busy=0 next edge, dout unchanged, no pulse, glitch_cnt unchanged.
//   - Re-enable with din_async held -> toggle 4 edges later (DEBOUNCE_CYCLES).
//  T6 chain
//   - dout drives dflipflop d -> its q follows dout one clk edge later.
//   - Glitch pulses shorter than 4 cycles never reach q.

Source files
------------

// File: rtl/debounce_sync.sv
// Synchronises an asynchronous level input, debounces it with a stability counter,
// and reports clean edges plus a saturating count of rejected glitches.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din_async,
  input  logic                enable,
  output logic                dout,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // state   | meaning
  // IDLE_LO | dout=0, no transition under test
  // CHK_HI  | dout=0, synced input high, counting stable cycles
  // IDLE_HI | dout=1, no transition under test
  // CHK_LO  | dout=1, synced input low, counting stable cycles
  typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt, idle_state, chk_state;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   dout_nxt, rise_nxt, fall_nxt;
  logic [GLITCH_W-1:0]    glitch_nxt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din_async};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LO;
      cnt        <= '0;
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
      glitch_cnt <= glitch_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dout_nxt   = dout;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_nxt = glitch_cnt;
    idle_state = dout ? IDLE_HI : IDLE_LO;
    chk_state  = dout ? CHK_LO : CHK_HI;
    if (!enable) begin
      state_nxt = idle_state;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE_LO, IDLE_HI: begin
          if (s != dout) begin
            state_nxt = chk_state;
            cnt_nxt   = CW'(1);
          end
        end
        CHK_HI, CHK_LO: begin
          if (s != dout) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
              dout_nxt  = ~dout;
              state_nxt = dout ? IDLE_LO : IDLE_HI;
              cnt_nxt   = '0;
              rise_nxt  = ~dout;
              fall_nxt  = dout;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            // input fell back before the check completed: count it, never wrap
            state_nxt = idle_state;
            cnt_nxt   = '0;
            if (glitch_cnt != '1) glitch_nxt = glitch_cnt + GLITCH_W'(1);
          end
        end
        default: begin
          state_nxt = idle_state;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule
